// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the 5-stage core.
package pipe_pkg;

    // Stage-register state; the encoding doubles as the held-entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    // Per-boundary bundle widths.
    localparam int unsigned IF_ID_CTRL_W  = 1;    // reserved single bit
    localparam int unsigned IF_ID_DATA_W  = 64;   // PC, instruction
    localparam int unsigned ID_EX_CTRL_W  = 14;
    localparam int unsigned ID_EX_DATA_W  = 140;
    localparam int unsigned EX_MEM_CTRL_W = 3;    // MEM_R_EN, MEM_W_EN, WB_EN
    localparam int unsigned EX_MEM_DATA_W = 68;   // ALU result, Val_Rm, Dest
    localparam int unsigned MEM_WB_CTRL_W = 2;    // MEM_R_EN, WB_EN
    localparam int unsigned MEM_WB_DATA_W = 68;   // ALU result, mem data, Dest
    localparam int unsigned STATS_CNT_W   = 16;

    // ID/EX control bundle field offsets (LSB positions) and widths.
    localparam int unsigned CTRL_SR_LSB       = 0;
    localparam int unsigned CTRL_SR_W         = 4;
    localparam int unsigned CTRL_EXE_CMD_LSB  = 4;
    localparam int unsigned CTRL_EXE_CMD_W    = 4;
    localparam int unsigned CTRL_IMM_BIT      = 8;
    localparam int unsigned CTRL_WB_EN_BIT    = 9;
    localparam int unsigned CTRL_MEM_W_EN_BIT = 10;
    localparam int unsigned CTRL_MEM_R_EN_BIT = 11;
    localparam int unsigned CTRL_B_BIT        = 12;
    localparam int unsigned CTRL_S_BIT        = 13;

    // Number of entries held in a given state.
    function automatic logic [1:0] state_occ(input pipe_state_t s);
        logic [1:0] occ;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating statistics counters for a pipeline stage register.
module pipe_stage_stats
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = STATS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic [1:0]       drop_num,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned SUM_W = CNT_W + 1;

    // Add a small increment, clamping at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, cnt} + SUM_W'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            stall_cnt <= sat_add(stall_cnt, {1'b0, stall});
            flush_cnt <= sat_add(flush_cnt, {1'b0, flush});
            drop_cnt  <= sat_add(drop_cnt, drop_num);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and 2-entry skid.
// Optional statistics counters are enabled with `define PIPE_STAGE_STATS_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = ID_EX_CTRL_W,
    parameter int unsigned DATA_W = ID_EX_DATA_W
`ifdef PIPE_STAGE_STATS_EN
   ,parameter int unsigned CNT_W  = STATS_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  drop_cnt
`endif
);

    pipe_state_t       state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = state_occ(state);

    // Skid FSM: main always holds the oldest entry, skid the younger one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            // Drop held entries and any concurrent input; a concurrent
            // out_fire has already been taken downstream.
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (in_fire) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        state     <= ST_FULL;
                        in_ready  <= 1'b0;
                    end else if (out_fire) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        state     <= ST_ONE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [1:0] drop_num;
    logic       stall;

    // Entries lost to a flush: those held, minus one leaving this cycle.
    assign drop_num = flush ? (occupancy - 2'(out_fire)) : 2'd0;
    assign stall    = out_valid & ~out_ready;

    pipe_stage_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .drop_num  (drop_num),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .drop_cnt  (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table plus randomized scoreboard.
module tb_pipe_stage_reg;

    localparam int unsigned CW = 14;
    localparam int unsigned DW = 140;
    localparam int unsigned NV = 22;
    localparam int unsigned NRAND = 10000;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;
    logic [15:0]   drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
       ,.stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic [CW-1:0] ic;
        logic          ev;
        logic          er;
        logic [1:0]    eo;
        logic          chk_pay;
        logic [CW-1:0] ec;
        logic [1:0]    edrop;
    } vec_t;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    vec_t tbl[NV];
    ent_t q[$];

    function automatic logic [DW-1:0] data_of(input logic [CW-1:0] c);
        return (c == '0) ? '0 : DW'({c, 8'hA5, c, 16'h5A5A});
    endfunction

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [CW-1:0] ic, input logic ev, input logic er,
                                input logic [1:0] eo, input logic chk_pay,
                                input logic [CW-1:0] ec, input logic [1:0] edrop);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ic = ic;
        v.ev = ev; v.er = er; v.eo = eo; v.chk_pay = chk_pay;
        v.ec = ec; v.edrop = edrop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = c;
        in_data   = d;
    endtask

    initial begin
        logic [1:0] occ_prev;
        bit         zeroed;
        int         m_stall;
        int         m_flush;
        int         m_drop;
`ifdef PIPE_STAGE_STATS_EN
        logic [15:0] fc0;
        logic [15:0] dc0;
`endif

        // Streaming 1..8 with out_ready held high.
        for (int k = 0; k < 8; k++)
            tbl[k] = mk(1, 1, 0, CW'(k + 1), 1, 1, 2'd1, 1, CW'(k + 1), 0);
        tbl[8]  = mk(0, 1, 0, '0,      0, 1, 2'd0, 0, '0,      0);
        // Skid fill under stall, rejected input while full, ordered drain.
        tbl[9]  = mk(1, 0, 0, 14'h11,  1, 1, 2'd1, 1, 14'h11,  0);
        tbl[10] = mk(1, 0, 0, 14'h22,  1, 0, 2'd2, 1, 14'h11,  0);
        tbl[11] = mk(1, 0, 0, 14'h99,  1, 0, 2'd2, 1, 14'h11,  0);
        tbl[12] = mk(0, 1, 0, '0,      1, 1, 2'd1, 1, 14'h22,  0);
        tbl[13] = mk(0, 1, 0, '0,      0, 1, 2'd0, 0, '0,      0);
        // Flush while full with a concurrent input C.
        tbl[14] = mk(1, 0, 0, 14'h11,  1, 1, 2'd1, 1, 14'h11,  0);
        tbl[15] = mk(1, 0, 0, 14'h22,  1, 0, 2'd2, 1, 14'h11,  0);
        tbl[16] = mk(1, 0, 1, 14'h33,  0, 1, 2'd0, 1, '0,      2);
        tbl[17] = mk(0, 1, 0, '0,      0, 1, 2'd0, 1, '0,      0);
        // Flush coincident with delivery of the head entry.
        tbl[18] = mk(1, 0, 0, 14'h44,  1, 1, 2'd1, 1, 14'h44,  0);
        tbl[19] = mk(1, 0, 0, 14'h55,  1, 0, 2'd2, 1, 14'h44,  0);
        tbl[20] = mk(0, 1, 1, '0,      0, 1, 2'd0, 1, '0,      1);
        // Flush while empty with an input that is accepted and discarded.
        tbl[21] = mk(1, 1, 1, 14'h66,  0, 1, 2'd0, 1, '0,      0);

        // Reset held low with live input.
        rst = 1'b0;
        drive(1, 1, 0, 14'h3FFF, {DW{1'b1}});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_out_valid", DW'(out_valid), '0);
            chk("rst_out_ctrl", DW'(out_ctrl), '0);
            chk("rst_out_data", out_data, '0);
            chk("rst_in_ready", DW'(in_ready), DW'(1));
            chk("rst_occupancy", DW'(occupancy), '0);
        end
        drive(0, 0, 0, '0, '0);
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < int'(NV); i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].ic, data_of(tbl[i].ic));
`ifdef PIPE_STAGE_STATS_EN
            fc0 = flush_cnt;
            dc0 = drop_cnt;
`endif
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(tbl[i].ev));
            chk($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(tbl[i].er));
            chk($sformatf("vec%0d_occupancy", i), DW'(occupancy), DW'(tbl[i].eo));
            if (tbl[i].chk_pay) begin
                chk($sformatf("vec%0d_out_ctrl", i), DW'(out_ctrl), DW'(tbl[i].ec));
                chk($sformatf("vec%0d_out_data", i), out_data, data_of(tbl[i].ec));
            end
`ifdef PIPE_STAGE_STATS_EN
            chk($sformatf("vec%0d_flush_cnt_delta", i), DW'(16'(flush_cnt - fc0)), DW'(tbl[i].fl));
            chk($sformatf("vec%0d_drop_cnt_delta", i), DW'(16'(drop_cnt - dc0)), DW'(tbl[i].edrop));
`endif
        end

        // Reset asserted mid-transfer with two entries held.
        drive(1, 0, 0, 14'h77, data_of(14'h77));
        @(posedge clk); #1;
        drive(1, 0, 0, 14'h78, data_of(14'h78));
        @(posedge clk); #1;
        occ_prev = occupancy;
        chk("midrst_prefill_occ", DW'(occ_prev), DW'(2));
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", DW'(out_valid), '0);
        chk("midrst_occupancy", DW'(occupancy), '0);
        chk("midrst_in_ready", DW'(in_ready), DW'(1));
        chk("midrst_out_ctrl", DW'(out_ctrl), '0);
        chk("midrst_out_data", out_data, '0);
        drive(0, 0, 0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_after_occ", DW'(occupancy), '0);

        // Randomized traffic against a queue model.
        zeroed  = 1'b1;
        m_stall = 0;
        m_flush = 0;
        m_drop  = 0;
        for (int n = 0; n < int'(NRAND); n++) begin
            logic          iv, ordy, fl, ifire, ofire;
            logic [CW-1:0] c;
            logic [DW-1:0] d;
            ent_t          e;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 31) == 0);
            c    = CW'($urandom());
            d    = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            drive(iv, ordy, fl, c, d);

            ifire = iv && (q.size() < 2);
            ofire = (q.size() > 0) && ordy;
            if (q.size() > 0 && !ordy) m_stall++;
            if (fl) begin
                m_flush++;
                m_drop += q.size() - int'(ofire);
                q.delete();
                zeroed = 1'b1;
            end else begin
                if (ofire) begin
                    void'(q.pop_front());
                    zeroed = 1'b0;
                end
                if (ifire) begin
                    e.c = c;
                    e.d = d;
                    q.push_back(e);
                    zeroed = 1'b0;
                end
            end

            @(posedge clk); #1;
            chk("rand_out_valid", DW'(out_valid), DW'(q.size() > 0));
            chk("rand_in_ready", DW'(in_ready), DW'(q.size() < 2));
            chk("rand_occupancy", DW'(occupancy), DW'(q.size()));
            if (q.size() > 0) begin
                chk("rand_out_ctrl", DW'(out_ctrl), DW'(q[0].c));
                chk("rand_out_data", out_data, q[0].d);
            end else if (zeroed) begin
                chk("rand_flushed_ctrl", DW'(out_ctrl), '0);
                chk("rand_flushed_data", out_data, '0);
            end
        end
`ifdef PIPE_STAGE_STATS_EN
        chk("rand_stall_cnt", DW'(stall_cnt), DW'(m_stall));
        chk("rand_flush_cnt", DW'(flush_cnt), DW'(m_flush));
        chk("rand_drop_cnt", DW'(drop_cnt), DW'(m_drop));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
